serial_add_controller: RTL
==========================

// Module: serial_add_controller
// PURPOSE
//   Bit-serial adder sequencer: time-shares one 1-bit full-adder cell
//   (S = a^b^c, Cout = a&b | c&(a^b)) across WIDTH bit positions, LSB first.
//   Latches operands on start, runs one bit per clock, holds the registered
//   result and pulses done. Low-area alternative to a WIDTH-bit ripple adder.
// PARAMETERS
//   WIDTH   8   operand/sum width in bits (>=2)
// PORTS
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only in IDLE or DONE
//   a      in   WIDTH  operand A, sampled with accepted start
//   b      in   WIDTH  operand B, sampled with accepted start
//   cin    in   1      carry-in, sampled with accepted start
//   busy   out  1      high while in RUN
//   done   out  1      one-cycle pulse: sum/cout just updated
//   sum    out  WIDTH  registered result, held until next completion
//   cout   out  1      registered carry-out, held with sum
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE; busy=0, done=0, sum=0, cout=0;
//     operand shift regs, carry reg, bit counter cleared. Overrides start.
//   States: IDLE, RUN, DONE (2-bit encoded).
//   IDLE: start=1 -> load A_sr=a, B_sr=b, carry=cin, cnt=0, partial=0; -> RUN.
//   RUN (busy=1): each edge: fa_s/fa_c from A_sr[0],B_sr[0],carry;
//     partial <= {fa_s, partial[WIDTH-1:1]}; A_sr,B_sr shift right (zero-fill);
//     carry <= fa_c; cnt <= cnt+1. cnt width = $clog2(WIDTH+1).
//     On edge where cnt==WIDTH-1: sum <= {fa_s, partial[WIDTH-1:1]},
//     cout <= fa_c; -> DONE.
//   DONE: done=1 for exactly this cycle. start=1 -> reload as IDLE, -> RUN
//     (back-to-back); else -> IDLE.
//   start while in RUN: ignored, no effect on operation or later state.
//   a/b/cin changes after acceptance: no effect on in-flight operation.
//   Latency: start accepted at edge k -> busy high after edges k+1..k+WIDTH-1
//     inclusive of edge k; done high in cycle following edge k+WIDTH;
//     i.e. done visible WIDTH edges after acceptance edge. Throughput: one
//     result per WIDTH+1 cycles (WIDTH RUN + 1 DONE).
//   sum/cout change only on the RUN->DONE edge and on reset; stable otherwise,
//     including throughout a following RUN.
//   Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1), exact.
//   Reset mid-RUN: operation aborted, no done pulse, outputs zero next cycle.
//   busy and done are never high in the same cycle.
// TESTING
//   1 Reset: hold rst 2 cycles with start=1 -> busy=0, done=0, sum=0, cout=0.
//   2 a=8'hFF,b=8'h01,cin=0 -> done exactly 8 edges after accept, sum=8'h00,
//     cout=1; busy high 8 cycles.
//   3 a=8'hA5,b=8'h5A,cin=1 -> sum=8'h00,cout=1; then a=8'h3C,b=8'h42,cin=0
//     started in DONE cycle -> no IDLE gap, sum=8'h7E,cout=0.
//   4 start a=8'h12,b=8'h34; pulse start with a=8'hFF,b=8'hFF mid-RUN and
//     change a/b -> result sum=8'h46,cout=0; only one done pulse.
//   5 start a=8'h80,b=8'h80; assert rst at 4th RUN cycle -> no done, outputs 0,
//     IDLE; new start a=8'h01,b=8'h02 -> sum=8'h03.
//   6 WIDTH=3 build: exhaustive a,b in 0..7, cin 0/1 (128 ops) vs a+b+cin
//     reference model; sum/cout stable between done pulses.

Source files
------------

// File: rtl/serial_add_controller.sv
// Bit-serial adder sequencer: one full-adder cell is reused across WIDTH bit
// positions, LSB first, and the registered result is held until the next completion.
module serial_add_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_sr_reg, a_sr_next;
  logic [WIDTH-1:0] b_sr_reg, b_sr_next;
  logic [WIDTH-1:0] partial_reg, partial_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;

  logic             fa_s, fa_c;
  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] a_shift, b_shift, partial_shift;

  // The single shared full-adder cell.
  assign fa_s     = a_sr_reg[0] ^ b_sr_reg[0] ^ carry_reg;
  assign fa_c     = (a_sr_reg[0] & b_sr_reg[0]) | (carry_reg & (a_sr_reg[0] ^ b_sr_reg[0]));
  assign accept   = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // Operands drain toward bit 0 with zero fill; fresh sum bits enter at the top.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == WIDTH - 1) begin : g_top
        assign a_shift[gi]       = 1'b0;
        assign b_shift[gi]       = 1'b0;
        assign partial_shift[gi] = fa_s;
      end else begin : g_mid
        assign a_shift[gi]       = a_sr_reg[gi+1];
        assign b_shift[gi]       = b_sr_reg[gi+1];
        assign partial_shift[gi] = partial_reg[gi+1];
      end
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    state_next = accept ? RUN : IDLE;
      RUN:     state_next = last_bit ? DONE : RUN;
      DONE:    state_next = accept ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  // Datapath next values; start during RUN never reaches here because accept is gated.
  always_comb begin
    a_sr_next    = a_sr_reg;
    b_sr_next    = b_sr_reg;
    partial_next = partial_reg;
    carry_next   = carry_reg;
    cnt_next     = cnt_reg;
    sum_next     = sum_reg;
    cout_next    = cout_reg;
    if (accept) begin
      a_sr_next    = a;
      b_sr_next    = b;
      carry_next   = cin;
      cnt_next     = '0;
      partial_next = '0;
    end else if (state_reg == RUN) begin
      a_sr_next    = a_shift;
      b_sr_next    = b_shift;
      partial_next = partial_shift;
      carry_next   = fa_c;
      cnt_next     = cnt_reg + CW'(1);
      if (last_bit) begin
        sum_next  = partial_shift;
        cout_next = fa_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_reg    <= '0;
      b_sr_reg    <= '0;
      partial_reg <= '0;
      carry_reg   <= 1'b0;
      cnt_reg     <= '0;
      sum_reg     <= '0;
      cout_reg    <= 1'b0;
    end else begin
      a_sr_reg    <= a_sr_next;
      b_sr_reg    <= b_sr_next;
      partial_reg <= partial_next;
      carry_reg   <= carry_next;
      cnt_reg     <= cnt_next;
      sum_reg     <= sum_next;
      cout_reg    <= cout_next;
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule
